// File: rtl/multiplier16x16_arbiter.sv
// rtl/multiplier16x16_arbiter.sv - round-robin arbiter sharing one 16x16 multiplier (option: MULT_ARB_STATS_EN adds grant_cnt)

// Combinational unsigned 16x16 -> 32 multiplier
module multiplier16x16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] p
);
  assign p = {16'd0, a} * {16'd0, b};
endmodule

module multiplier16x16_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [16*NUM_REQ-1:0] a_in,
  input  logic [16*NUM_REQ-1:0] b_in,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [31:0]           p_out,
  output logic [ID_W-1:0]       p_id,
  output logic                  p_valid,
`ifdef MULT_ARB_STATS_EN
  output logic [15:0]           grant_cnt,
`endif
  input  logic                  p_ready
);

  typedef enum logic [1:0] {IDLE, MUL, RESP} state_t;

  state_t          state, state_next;
  logic [ID_W-1:0] rr_ptr, rr_next, winner, id_r;
  logic [ID_W-1:0] hi_w, lo_w;
  logic            hi_found, lo_found, grant;
  logic [15:0]     a_r, b_r, a_sel, b_sel;
  logic [31:0]     prod;

  multiplier16x16 u_mult (
    .a (a_r),
    .b (b_r),
    .p (prod)
  );

  // Round-robin pick: lowest requester at or above rr_ptr, else lowest overall
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_w     = '0;
    lo_w     = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_found = 1'b1;
        lo_w     = ID_W'(i);
        if (ID_W'(i) >= rr_ptr) begin
          hi_found = 1'b1;
          hi_w     = ID_W'(i);
        end
      end
    end
    winner  = hi_found ? hi_w : lo_w;
    rr_next = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
  end

  // Operand mux for the winning requester
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == winner) begin
        a_sel = a_in[16*i +: 16];
        b_sel = b_in[16*i +: 16];
      end
    end
  end

  // Next-state logic; grants are only evaluated in IDLE
  always_comb begin
    state_next = state;
    grant      = 1'b0;
    case (state)
      IDLE: begin
        if (lo_found) begin
          grant      = 1'b1;
          state_next = MUL;
        end
      end
      MUL:     state_next = RESP;
      RESP:    if (p_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Grant, operand capture, product register and result handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt     <= '0;
      rr_ptr  <= '0;
      a_r     <= '0;
      b_r     <= '0;
      id_r    <= '0;
      p_out   <= '0;
      p_id    <= '0;
      p_valid <= 1'b0;
    end else begin
      gnt <= '0;
      if (grant) begin
        a_r    <= a_sel;
        b_r    <= b_sel;
        id_r   <= winner;
        gnt    <= NUM_REQ'(1) << winner;
        rr_ptr <= rr_next;
      end
      if (state == MUL) begin
        p_out   <= prod;
        p_id    <= id_r;
        p_valid <= 1'b1;
      end
      if (state == RESP && p_ready) p_valid <= 1'b0;
    end
  end

`ifdef MULT_ARB_STATS_EN
  // Count grant pulses, wrapping at 16 bits
  always_ff @(posedge clk) begin
    if (rst)        grant_cnt <= '0;
    else if (grant) grant_cnt <= grant_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_multiplier16x16_arbiter.sv
// tb/tb_multiplier16x16_arbiter.sv - directed vector bench for multiplier16x16_arbiter
module tb_multiplier16x16_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [63:0] a_in, b_in;
  logic [3:0]  gnt;
  logic [31:0] p_out;
  logic [1:0]  p_id;
  logic        p_valid;
  logic        p_ready;
`ifdef MULT_ARB_STATS_EN
  logic [15:0] grant_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  multiplier16x16_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .a_in      (a_in),
    .b_in      (b_in),
    .gnt       (gnt),
    .p_out     (p_out),
    .p_id      (p_id),
    .p_valid   (p_valid),
`ifdef MULT_ARB_STATS_EN
    .grant_cnt (grant_cnt),
`endif
    .p_ready   (p_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  exp_gnt;
    logic [31:0] exp_p;
    logic [1:0]  exp_id;
  } vec_t;

  vec_t vecs[8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  logic [15:0] fa[4];
  logic [15:0] fb[4];
  int          order[6];

  initial begin
    // req, a, b, expected gnt, product, id (rr_ptr tracked by hand, starts at 0)
    vecs[0] = '{4'b0001, 16'd3,     16'd5,     4'b0001, 32'd15,         2'd0};
    vecs[1] = '{4'b0100, 16'hFFFF,  16'hFFFF,  4'b0100, 32'hFFFE0001,   2'd2};
    vecs[2] = '{4'b0100, 16'h0000,  16'hFFFF,  4'b0100, 32'h0,          2'd2};
    vecs[3] = '{4'b0011, 16'h1234,  16'h0010,  4'b0001, 32'h00012340,   2'd0};
    vecs[4] = '{4'b0011, 16'hFFFF,  16'h0001,  4'b0010, 32'h0000FFFF,   2'd1};
    vecs[5] = '{4'b1000, 16'h8000,  16'h0002,  4'b1000, 32'h00010000,   2'd3};
    vecs[6] = '{4'b1010, 16'd100,   16'd200,   4'b0010, 32'd20000,      2'd1};
    vecs[7] = '{4'b1010, 16'hABCD,  16'h0000,  4'b1000, 32'h0,          2'd3};

    // Reset with random stimulus present
    rst     = 1'b1;
    req     = 4'($urandom());
    a_in    = {$urandom(), $urandom()};
    b_in    = {$urandom(), $urandom()};
    p_ready = 1'($urandom());
    for (int c = 0; c < 2; c++) begin
      step();
      check("rst_gnt", 32'(gnt), 32'h0);
      check("rst_p_valid", 32'(p_valid), 32'h0);
      check("rst_p_out", p_out, 32'h0);
      check("rst_p_id", 32'(p_id), 32'h0);
      req = 4'($urandom());
    end
`ifdef MULT_ARB_STATS_EN
    check("rst_grant_cnt", 32'(grant_cnt), 32'h0);
`endif
    rst     = 1'b0;
    req     = 4'b0000;
    p_ready = 1'b1;
    step();
    check("idle_no_gnt", 32'(gnt), 32'h0);

    // Table-driven single transactions with p_ready high
    for (int i = 0; i < 8; i++) begin
      req  = vecs[i].req;
      a_in = {4{vecs[i].a}};
      b_in = {4{vecs[i].b}};
      step();
      check($sformatf("v%0d_gnt", i), 32'(gnt), 32'(vecs[i].exp_gnt));
      req = 4'b0000;
      step();
      check($sformatf("v%0d_p_valid", i), 32'(p_valid), 32'h1);
      check($sformatf("v%0d_p_out", i), p_out, vecs[i].exp_p);
      check($sformatf("v%0d_p_id", i), 32'(p_id), 32'(vecs[i].exp_id));
      check($sformatf("v%0d_gnt_drop", i), 32'(gnt), 32'h0);
      step();
      check($sformatf("v%0d_p_valid_drop", i), 32'(p_valid), 32'h0);
    end

    // Fairness: all requesting, rr_ptr is 0 here
    for (int i = 0; i < 4; i++) begin
      fa[i] = 16'(16'h0101 * (i + 1));
      fb[i] = 16'(16'h0100 + 3 * i + 7);
    end
    a_in  = {fa[3], fa[2], fa[1], fa[0]};
    b_in  = {fb[3], fb[2], fb[1], fb[0]};
    order = '{0, 1, 2, 3, 0, 1};
    req   = 4'b1111;
    for (int g = 0; g < 6; g++) begin
      step();
      check($sformatf("fair%0d_gnt", g), 32'(gnt), 32'(4'b0001 << order[g]));
      step();
      check($sformatf("fair%0d_gnt_mul", g), 32'(gnt), 32'h0);
      check($sformatf("fair%0d_p_out", g), p_out,
            {16'd0, fa[order[g]]} * {16'd0, fb[order[g]]});
      check($sformatf("fair%0d_p_id", g), 32'(p_id), 32'(order[g]));
      step();
      check($sformatf("fair%0d_p_valid_drop", g), 32'(p_valid), 32'h0);
      check($sformatf("fair%0d_gnt_resp", g), 32'(gnt), 32'h0);
    end
    req = 4'b0000;

    // Backpressure in RESP with req[1] pending, rr_ptr is 2
    a_in    = {4{16'd7}};
    b_in    = {4{16'd9}};
    p_ready = 1'b0;
    req     = 4'b0100;
    step();
    check("bp_gnt", 32'(gnt), 32'b0100);
    req = 4'b0010;
    step();
    check("bp_p_valid", 32'(p_valid), 32'h1);
    for (int c = 0; c < 5; c++) begin
      step();
      check($sformatf("bp%0d_p_valid", c), 32'(p_valid), 32'h1);
      check($sformatf("bp%0d_p_out", c), p_out, 32'd63);
      check($sformatf("bp%0d_p_id", c), 32'(p_id), 32'd2);
      check($sformatf("bp%0d_gnt", c), 32'(gnt), 32'h0);
    end
    p_ready = 1'b1;
    step();
    check("bp_release_p_valid", 32'(p_valid), 32'h0);
    check("bp_release_gnt", 32'(gnt), 32'h0);
    step();
    check("bp_next_gnt", 32'(gnt), 32'b0010);
    req = 4'b0000;
    step();
    check("bp_next_p_id", 32'(p_id), 32'd1);
    step();

    // Reset while a result is waiting, rr_ptr is 2
    p_ready = 1'b0;
    req     = 4'b1000;
    step();
    check("mr_gnt", 32'(gnt), 32'b1000);
    req = 4'b0000;
    step();
    check("mr_p_valid", 32'(p_valid), 32'h1);
    check("mr_p_id", 32'(p_id), 32'd3);
    rst = 1'b1;
    step();
    check("mr_rst_p_valid", 32'(p_valid), 32'h0);
    check("mr_rst_p_out", p_out, 32'h0);
    check("mr_rst_p_id", 32'(p_id), 32'h0);
`ifdef MULT_ARB_STATS_EN
    check("mr_rst_grant_cnt", 32'(grant_cnt), 32'h0);
`endif
    rst     = 1'b0;
    p_ready = 1'b1;
    req     = 4'b1001;
    step();
    check("mr_gnt_after_rst", 32'(gnt), 32'b0001);
`ifdef MULT_ARB_STATS_EN
    check("mr_grant_cnt_one", 32'(grant_cnt), 32'h1);
`endif
    req = 4'b0000;
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
